// File: rtl/post_cipher_ser_if.sv
// post_cipher_ser_if: cipher-block input, last-block request and serial output stream of post_cipher_ser
interface post_cipher_ser_if #(
  parameter int BLOCK_W = 64,
  parameter int OUT_W   = 1
);
  logic [BLOCK_W-1:0]        cipher_in;
  logic                      cipher_wr;
  logic                      cipher_busy;
  logic                      cipher_full;
  logic                      overflow;
  logic [BLOCK_W-1:0]        last_in;
  logic [$clog2(BLOCK_W):0]  last_cnt;
  logic                      last_filled;
  logic                      last_ack;
  logic [OUT_W-1:0]          sign_out;
  logic                      sign_en;
  logic                      sign_ready;
  logic [$clog2(OUT_W):0]    sign_lanes;
  logic                      sign_last;
  modport master (
    output cipher_in, cipher_wr, cipher_busy, last_in, last_cnt, last_filled, sign_ready,
    input  cipher_full, overflow, last_ack, sign_out, sign_en, sign_lanes, sign_last
  );
  modport slave (
    input  cipher_in, cipher_wr, cipher_busy, last_in, last_cnt, last_filled, sign_ready,
    output cipher_full, overflow, last_ack, sign_out, sign_en, sign_lanes, sign_last
  );
endinterface

// File: rtl/post_cipher_ser.sv
// post_cipher_ser: buffers cipher blocks in a FIFO and serializes them OUT_W bits per beat, then one variable-length last block
module post_cipher_ser #(
  parameter int BLOCK_W    = 64,
  parameter int OUT_W      = 1,
  parameter int FIFO_DEPTH = 2,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  post_cipher_ser_if.slave bus
);
  localparam int NB = BLOCK_W / OUT_W;
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(BLOCK_W) + 1;
  localparam int LW = $clog2(OUT_W) + 1;
  localparam int SH = $clog2(OUT_W);
  typedef enum logic [1:0] {IDLE, SHIFT_C, SHIFT_L} state_t;
  state_t             state_q, state_d;
  logic [BLOCK_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wp_q, rp_q;
  logic [CW-1:0]      cnt_q;
  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]      beats_q, beats_d;
  logic [LW-1:0]      lanes_q, lanes_d;
  logic               ack_q, ack_d, ovf_q;
  logic               full, empty, push, pop, fin;
  logic [BLOCK_W-1:0] one, last_ld, shifted;
  logic [BW-1:0]      last_beats;
  logic [LW-1:0]      last_lanes;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  // full is judged before any pop of the same edge, so a push into a full FIFO is always dropped
  assign push  = clk_en && bus.cipher_wr && !full;
  assign fin   = beats_q == BW'(1);
  assign one   = BLOCK_W'(1);
  // the last block is masked to last_cnt bits so unused lanes of its final beat read 0
  assign last_ld = MSB_FIRST ? bus.last_in << (BW'(BLOCK_W) - bus.last_cnt)
                             : bus.last_in & ((one << bus.last_cnt) - one);
  assign last_beats = (bus.last_cnt + BW'(OUT_W - 1)) >> SH;
  assign last_lanes = LW'(bus.last_cnt - ((last_beats - BW'(1)) << SH));
  assign shifted = MSB_FIRST ? shreg_q << OUT_W : shreg_q >> OUT_W;
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.cipher_in;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      shreg_q <= '0;
      beats_q <= '0;
      lanes_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      if (push) wp_q <= inc(wp_q);
      if (pop) rp_q <= inc(rp_q);
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
      if (clk_en && bus.cipher_wr && full) ovf_q <= 1'b1;
      state_q <= state_d;
      shreg_q <= shreg_d;
      beats_q <= beats_d;
      lanes_q <= lanes_d;
      ack_q   <= ack_d;
    end
  end
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    beats_d = beats_q;
    lanes_d = lanes_q;
    ack_d   = clk_en ? 1'b0 : ack_q;
    pop     = 1'b0;
    if (clk_en) begin
      if (state_q == IDLE) begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rp_q];
          beats_d = BW'(NB);
          state_d = SHIFT_C;
        end else if (!bus.cipher_busy && bus.last_filled && !ack_q) begin
          ack_d = 1'b1;
          if (bus.last_cnt != '0) begin
            shreg_d = last_ld;
            beats_d = last_beats;
            lanes_d = last_lanes;
            state_d = SHIFT_L;
          end
        end
      end else if (bus.sign_ready) begin
        if (!fin) begin
          shreg_d = shifted;
          beats_d = beats_q - BW'(1);
        end else if (state_q == SHIFT_C && !empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rp_q];
          beats_d = BW'(NB);
        end else begin
          state_d = IDLE;
        end
      end
    end
  end
  assign bus.sign_en     = state_q != IDLE;
  assign bus.sign_last   = state_q == SHIFT_L && fin;
  assign bus.sign_lanes  = !bus.sign_en ? '0 : bus.sign_last ? lanes_q : LW'(OUT_W);
  assign bus.sign_out    = !bus.sign_en ? '0 : MSB_FIRST ? shreg_q[BLOCK_W-1 -: OUT_W] : shreg_q[OUT_W-1:0];
  assign bus.cipher_full = full;
  assign bus.overflow    = ovf_q;
  assign bus.last_ack    = ack_q;
endmodule

// File: tb/tb_post_cipher_ser.sv
// tb_post_cipher_ser: random and directed stimulus against a bit-queue reference model of the serializer
module tb_post_cipher_ser;
  logic clk = 1'b0, rst = 1'b1, en0 = 1'b0, en8 = 1'b0;
  always #5 clk = ~clk;
  post_cipher_ser_if #(.BLOCK_W(64), .OUT_W(1)) if0();
  post_cipher_ser_if #(.BLOCK_W(64), .OUT_W(8)) if8();
  post_cipher_ser dut0 (.clk(clk), .rst(rst), .clk_en(en0), .bus(if0));
  post_cipher_ser #(.BLOCK_W(64), .OUT_W(8), .FIFO_DEPTH(2), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst(rst), .clk_en(en8), .bus(if8));
  int total = 0, bad = 0;
  logic [63:0] mq[$];
  bit bq[$];
  bit m_last = 0, m_ovf = 0, m_ack = 0;
  logic [63:0] v8;
  int n8, acks;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic load_bits(input logic [63:0] v, input int n, input bit is_last);
    m_last = is_last;
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endtask
  // one clock edge of the reference: blocks are bit lists, the FIFO is a queue of at most two blocks
  task automatic model_step();
    bit full, ack_n;
    full = mq.size() == 2;
    ack_n = 0;
    if (!en0) return;
    if (bq.size() != 0) begin
      if (if0.sign_ready) begin
        bq.delete(0);
        if (bq.size() == 0 && !m_last && mq.size() != 0) load_bits(mq.pop_front(), 64, 0);
      end
    end else if (mq.size() != 0) begin
      load_bits(mq.pop_front(), 64, 0);
    end else if (!if0.cipher_busy && if0.last_filled && !m_ack) begin
      ack_n = 1;
      if (if0.last_cnt != 0) load_bits(if0.last_in, int'(if0.last_cnt), 1);
    end
    m_ack = ack_n;
    if (if0.cipher_wr) begin
      if (full) m_ovf = 1;
      else mq.push_back(if0.cipher_in);
    end
  endtask
  task automatic compare();
    bit e, b;
    e = bq.size() != 0;
    b = 0;
    if (e) b = bq[0];
    check("sign_en", 64'(if0.sign_en), 64'(e));
    check("sign_out", 64'(if0.sign_out), 64'(b));
    check("sign_last", 64'(if0.sign_last), 64'(e && m_last && bq.size() == 1));
    check("sign_lanes", 64'(if0.sign_lanes), 64'(e));
    check("cipher_full", 64'(if0.cipher_full), 64'(mq.size() == 2));
    check("overflow", 64'(if0.overflow), 64'(m_ovf));
    check("last_ack", 64'(if0.last_ack), 64'(m_ack));
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask
  task automatic requester();
    if (if0.last_filled && m_ack) if0.last_filled = 0;
  endtask
  task automatic drive_random();
    en0 = $urandom_range(0, 9) != 0;
    if0.cipher_wr = $urandom_range(0, 39) == 0;
    if0.cipher_in = {$urandom, $urandom};
    if0.sign_ready = $urandom_range(0, 3) != 0;
    if ($urandom_range(0, 15) == 0) if0.cipher_busy = ~if0.cipher_busy;
    if (if0.last_filled) requester();
    else if ($urandom_range(0, 59) == 0) begin
      if0.last_filled = 1;
      if0.last_in = {$urandom, $urandom};
      if0.last_cnt = 7'($urandom_range(0, 64));
    end
  endtask
  initial begin
    {if0.cipher_in, if0.cipher_wr, if0.cipher_busy, if0.last_in, if0.last_cnt, if0.last_filled, if0.sign_ready} = '0;
    {if8.cipher_in, if8.cipher_wr, if8.cipher_busy, if8.last_in, if8.last_cnt, if8.last_filled, if8.sign_ready} = '0;
    repeat (3) @(posedge clk);
    #1;
    compare();
    check("r8_en", 64'(if8.sign_en), 0);
    check("r8_out", 64'(if8.sign_out), 0);
    check("r8_lanes", 64'(if8.sign_lanes), 0);
    rst = 0;
    en8 = 1;
    // OUT_W=8, LSB-first last block of 30 bits with garbage above bit 29
    v8 = {$urandom, $urandom} | 64'hC000_0000;
    @(negedge clk);
    if8.last_in = v8;
    if8.last_cnt = 30;
    if8.last_filled = 1;
    if8.sign_ready = 1;
    n8 = 0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if8.last_ack) begin
        acks++;
        if8.last_filled = 0;
      end
      if (if8.sign_en) begin
        check("l8_out", 64'(if8.sign_out), ((v8 & 64'h3FFF_FFFF) >> (8 * n8)) & 64'hFF);
        check("l8_lanes", 64'(if8.sign_lanes), n8 < 3 ? 64'd8 : 64'd6);
        check("l8_last", 64'(if8.sign_last), 64'(n8 == 3));
        n8++;
      end
    end
    check("l8_beats", 64'(n8), 4);
    check("l8_acks", 64'(acks), 1);
    v8 = {$urandom, $urandom};
    @(negedge clk);
    if8.cipher_in = v8;
    if8.cipher_wr = 1;
    n8 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if8.cipher_wr = 0;
      if (if8.sign_en) begin
        check("c8_out", 64'(if8.sign_out), (v8 >> (8 * n8)) & 64'hFF);
        check("c8_lanes", 64'(if8.sign_lanes), 8);
        check("c8_last", 64'(if8.sign_last), 0);
        n8++;
      end
    end
    check("c8_beats", 64'(n8), 8);
    // alternating block, then ready 1,0,0,1 and a clk_en gap mid-block
    @(posedge clk);
    #1;
    en0 = 1;
    if0.sign_ready = 1;
    if0.cipher_in = 64'hAAAA_AAAA_AAAA_AAAA;
    if0.cipher_wr = 1;
    cycle();
    if0.cipher_wr = 0;
    repeat (10) cycle();
    if0.sign_ready = 0;
    repeat (2) cycle();
    if0.sign_ready = 1;
    cycle();
    en0 = 0;
    repeat (5) cycle();
    en0 = 1;
    repeat (70) cycle();
    // back-to-back blocks, then a push into a full FIFO
    foreach (mq[i]) ;
    for (int i = 0; i < 6; i++) begin
      if0.cipher_in = {$urandom, $urandom};
      if0.cipher_wr = i == 0 || i >= 3;
      cycle();
    end
    if0.cipher_wr = 0;
    repeat (220) cycle();
    // single-bit last block, then the same held off by cipher_busy
    if0.last_in = 64'h5555_5555_5555_5555;
    if0.last_cnt = 1;
    if0.last_filled = 1;
    repeat (4) begin cycle(); requester(); end
    if0.cipher_busy = 1;
    if0.last_filled = 1;
    repeat (8) begin cycle(); requester(); end
    if0.cipher_busy = 0;
    repeat (6) begin cycle(); requester(); end
    repeat (4000) begin drive_random(); cycle(); end
    // reset mid-block with another block queued
    en0 = 1;
    if0.sign_ready = 1;
    if0.cipher_busy = 1;
    if0.last_filled = 0;
    if0.cipher_wr = 0;
    repeat (300) cycle();
    if0.cipher_in = {$urandom, $urandom};
    if0.cipher_wr = 1;
    cycle();
    if0.cipher_wr = 0;
    repeat (2) cycle();
    if0.cipher_in = {$urandom, $urandom};
    if0.cipher_wr = 1;
    cycle();
    if0.cipher_wr = 0;
    repeat (16) cycle();
    check("pre_rst_busy", 64'(if0.sign_en && if0.cipher_full == 0), 1);
    #3;
    rst = 1;
    mq.delete();
    bq.delete();
    m_ovf = 0;
    m_ack = 0;
    m_last = 0;
    #1;
    compare();
    @(posedge clk);
    #1;
    compare();
    rst = 0;
    repeat (100) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
